// File: rtl/p4_router_pkg.sv
// Shared types for the P4 router ingress/egress schedulers.
// Default sizing and the arbiter state encoding.
package p4_router_pkg;

  localparam int P4_NUM_PORTS     = 4;
  localparam int P4_DATA_BYTES    = 64;
  localparam int P4_PORT_ID_WIDTH = $clog2(P4_NUM_PORTS);
  localparam int P4_CNT_WIDTH     = 32;

  typedef logic [P4_PORT_ID_WIDTH-1:0] ing_port_id_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/p4_router_ing_arb_if.sv
// AXIS bundle around the ingress arbiter: N ingress streams in, one converged stream out.
// master = environment side (upstream buffers + downstream sink), slave = the arbiter.
interface p4_router_ing_arb_if #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_BYTES    = 64,
  parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]              in_tvalid;
  logic [NUM_PORTS-1:0]              in_tready;
  logic [NUM_PORTS*DATA_BYTES*8-1:0] in_tdata;
  logic [NUM_PORTS*DATA_BYTES-1:0]   in_tkeep;
  logic [NUM_PORTS-1:0]              in_tlast;

  logic                              out_tvalid;
  logic                              out_tready;
  logic [DATA_BYTES*8-1:0]           out_tdata;
  logic [DATA_BYTES-1:0]             out_tkeep;
  logic                              out_tlast;
  logic [PORT_ID_WIDTH-1:0]          out_tuser;
  logic                              out_sof;

  modport master (
    output in_tvalid, in_tdata, in_tkeep, in_tlast, out_tready,
    input  in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser, out_sof
  );

  modport slave (
    input  in_tvalid, in_tdata, in_tkeep, in_tlast, out_tready,
    output in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser, out_sof
  );
endinterface

// File: rtl/p4_router_rr_pick.sv
// Combinational round-robin pick: first set bit of req searching upward from ptr, wrapping.
// Shared by the ingress arbiter and the egress scheduler.
module p4_router_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Walk from farthest to nearest so the nearest requester from ptr wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[IDX_W'((int'(ptr) + i) % N)]) begin
        gnt_idx   = IDX_W'((int'(ptr) + i) % N);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/p4_router_ing_arb.sv
// Packet-granular round-robin arbiter merging N ingress buffers onto the VNP4 ingress AXIS bus.
// Tags each packet with its source port in tuser and counts forwarded packets per port.
//
//   state    | meaning
//   ARB_IDLE | arbitration cycle: pick next eligible port from rr_ptr, register as grant
//   ARB_XFER | forward beats of the granted port until its tlast beat is accepted
module p4_router_ing_arb
  import p4_router_pkg::*;
#(
  parameter int NUM_PORTS     = P4_NUM_PORTS,
  parameter int DATA_BYTES    = P4_DATA_BYTES,
  parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS),
  parameter int CNT_WIDTH     = P4_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [NUM_PORTS-1:0]           port_en,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_cnt,
  p4_router_ing_arb_if.slave             bus
);

  localparam int DW = DATA_BYTES * 8;

  arb_state_t                          state_q, state_d;
  logic [PORT_ID_WIDTH-1:0]            grant_q, grant_d;
  logic [PORT_ID_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PORT_ID_WIDTH-1:0]            pick_idx;
  logic                                pick_vld;
  logic [NUM_PORTS-1:0]                eligible;
  logic [NUM_PORTS-1:0]                in_tready_c;
  logic                                room;
  logic                                accept;
  logic                                accept_last;
  logic                                first_q;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                                out_tvalid_q;
  logic [DW-1:0]                       out_tdata_q;
  logic [DATA_BYTES-1:0]               out_tkeep_q;
  logic                                out_tlast_q;
  logic [PORT_ID_WIDTH-1:0]            out_tuser_q;
  logic                                out_sof_q;

  assign eligible = bus.in_tvalid & port_en;

  p4_router_rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (PORT_ID_WIDTH)
  ) u_rr_pick (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_vld)
  );

  // The output stage can take a beat when empty or being drained this cycle.
  assign room        = ~out_tvalid_q | bus.out_tready;
  assign accept      = (state_q == ARB_XFER) && bus.in_tvalid[grant_q] && room;
  assign accept_last = accept && bus.in_tlast[grant_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    in_tready_c = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        in_tready_c[grant_q] = room;
        if (accept_last) begin
          rr_ptr_d = (grant_q == PORT_ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept_last) begin
      cnt_d[grant_q] = cnt_q[grant_q] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      first_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (state_q == ARB_IDLE) begin
        first_q <= 1'b1;
      end else if (accept) begin
        first_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tuser_q  <= '0;
      out_sof_q    <= 1'b0;
    end else if (accept) begin
      out_tvalid_q <= 1'b1;
      out_tdata_q  <= bus.in_tdata[int'(grant_q) * DW +: DW];
      out_tkeep_q  <= bus.in_tkeep[int'(grant_q) * DATA_BYTES +: DATA_BYTES];
      out_tlast_q  <= bus.in_tlast[grant_q];
      out_tuser_q  <= grant_q;
      out_sof_q    <= first_q;
    end else if (bus.out_tready) begin
      out_tvalid_q <= 1'b0;
    end
  end

  assign bus.in_tready  = in_tready_c;
  assign bus.out_tvalid = out_tvalid_q;
  assign bus.out_tdata  = out_tdata_q;
  assign bus.out_tkeep  = out_tkeep_q;
  assign bus.out_tlast  = out_tlast_q;
  assign bus.out_tuser  = out_tuser_q;
  assign bus.out_sof    = out_sof_q;
  assign pkt_cnt        = cnt_q;

endmodule

// File: tb/tb_p4_router_ing_arb.sv
// Self-checking bench for p4_router_ing_arb: directed scenarios plus randomized packet mixes
// against a per-port scoreboard and a round-robin order model.
module tb_p4_router_ing_arb;
  import p4_router_pkg::*;

  localparam int NP = 4;
  localparam int DB = 64;
  localparam int DW = DB * 8;
  localparam int CW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            aresetn;
  logic [NP-1:0]   port_en;
  logic [NP*CW-1:0] pkt_cnt;

  always #5 clk = ~clk;

  p4_router_ing_arb_if #(.NUM_PORTS(NP), .DATA_BYTES(DB)) bus ();

  p4_router_ing_arb #(
    .NUM_PORTS  (NP),
    .DATA_BYTES (DB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .port_en (port_en),
    .pkt_cnt (pkt_cnt),
    .bus     (bus)
  );

  beat_t         src_q[NP][$];
  beat_t         exp_q[NP][$];
  bit            mid[NP];
  bit            shown[NP];
  bit            acc[NP];
  bit            exp_sof[NP];
  logic [CW-1:0] cnt_model[NP];
  int            got_order[$];
  int            want_order[$];
  int            out_cyc[$];
  int            cur_port;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            first_out_cyc;
  int            out_beats;
  bit            gap_en;
  int            rdy_mode;
  logic          rdy_val;
  bit            hold_prev;
  logic [639:0]  prev_sig;
  logic [NP-1:0][CW-1:0] preload;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flush();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      mid[p]       = 1'b0;
      shown[p]     = 1'b0;
      acc[p]       = 1'b0;
      exp_sof[p]   = 1'b1;
      cnt_model[p] = '0;
    end
    got_order.delete();
    out_cyc.delete();
    first_out_cyc = -1;
    out_beats     = 0;
    cur_port      = 0;
    hold_prev     = 1'b0;
  endtask

  task automatic push_pkt(input int p, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
      b.keep = {$urandom(), $urandom()};
      b.last = (i == nbeats - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  task automatic present();
    bit v;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() == 0)  v = 1'b0;
      else if (shown[p])         v = 1'b1;
      else if (!mid[p])          v = 1'b1;
      else                       v = gap_en ? ($urandom_range(2) != 0) : 1'b1;
      shown[p] = v;
      bus.in_tvalid[p] = v;
      if (src_q[p].size() != 0) begin
        bus.in_tdata[p*DW +: DW] = src_q[p][0].data;
        bus.in_tkeep[p*DB +: DB] = src_q[p][0].keep;
        bus.in_tlast[p]          = src_q[p][0].last;
      end else begin
        bus.in_tdata[p*DW +: DW] = '0;
        bus.in_tkeep[p*DB +: DB] = '0;
        bus.in_tlast[p]          = 1'b0;
      end
    end
    if (rdy_mode == 0)      bus.out_tready = 1'b1;
    else if (rdy_mode == 1) bus.out_tready = 1'($urandom_range(1));
    else                    bus.out_tready = rdy_val;
  endtask

  task automatic advance();
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        b        = src_q[p].pop_front();
        mid[p]   = !b.last;
        shown[p] = 1'b0;
        acc[p]   = 1'b0;
      end
    end
  endtask

  task automatic sample();
    logic [639:0] sig;
    ing_port_id_t tu;
    beat_t        b;
    int           p;
    sig = {59'd0, bus.out_tvalid, bus.out_tdata, bus.out_tkeep, bus.out_tlast, bus.out_tuser, bus.out_sof};
    if (hold_prev) chk("out_stable_under_stall", sig, prev_sig);
    if (bus.out_tvalid && !bus.out_tready) chk("in_tready_during_stall", bus.in_tready, 0);
    chk("in_tready_onehot0", $onehot0(bus.in_tready), 1);
    if (bus.out_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
    for (int q = 0; q < NP; q++) acc[q] = bus.in_tvalid[q] & bus.in_tready[q];
    if (bus.out_tvalid && bus.out_tready) begin
      tu = bus.out_tuser;
      p  = int'(tu);
      chk("beat_expected_for_port", exp_q[p].size() != 0, 1);
      if (exp_q[p].size() != 0) begin
        b = exp_q[p].pop_front();
        chk("out_tdata", bus.out_tdata, b.data);
        chk("out_tkeep", bus.out_tkeep, b.keep);
        chk("out_tlast", bus.out_tlast, b.last);
        chk("out_sof", bus.out_sof, exp_sof[p]);
        if (!exp_sof[p]) chk("tuser_constant_in_pkt", p, cur_port);
        if (exp_sof[p]) got_order.push_back(p);
        cur_port   = p;
        exp_sof[p] = b.last;
        if (b.last) cnt_model[p] = cnt_model[p] + 1'b1;
        out_cyc.push_back(cyc);
        out_beats++;
      end
    end
    hold_prev = bus.out_tvalid && !bus.out_tready;
    prev_sig  = sig;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    advance();
    present();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_out_tvalid", bus.out_tvalid, 0);
    chk("rst_out_sof", bus.out_sof, 0);
    chk("rst_out_tlast", bus.out_tlast, 0);
    chk("rst_out_tuser", bus.out_tuser, 0);
    chk("rst_out_tdata", bus.out_tdata, 0);
    chk("rst_out_tkeep", bus.out_tkeep, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_in_tready", bus.in_tready, 0);
    flush();
    present();
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic drain(input string tag, input int max, input logic [NP-1:0] mask);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      done = !bus.out_tvalid;
      for (int p = 0; p < NP; p++) if (mask[p] && exp_q[p].size() != 0) done = 1'b0;
    end
    chk({"drain_", tag}, done, 1);
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_count"}, got_order.size(), want_order.size());
    for (int i = 0; i < want_order.size() && i < got_order.size(); i++)
      chk({tag, "_grant"}, got_order[i], want_order[i]);
    got_order.delete();
  endtask

  task automatic check_cnt(input string tag);
    for (int p = 0; p < NP; p++) chk(tag, pkt_cnt[p*CW +: CW], cnt_model[p]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int npk[NP];
    int left[NP];
    int ptr;
    int pick;
    int start_beats;
    bit hit;

    aresetn        = 1'b1;
    port_en        = '1;
    bus.in_tvalid  = '0;
    bus.in_tdata   = '0;
    bus.in_tkeep   = '0;
    bus.in_tlast   = '0;
    bus.out_tready = 1'b1;
    gap_en         = 1'b0;
    rdy_mode       = 0;
    rdy_val        = 1'b1;
    flush();
    #1;
    do_reset();

    // Port 2 alone, 3-beat packet: latency, tuser, sof, counter.
    push_pkt(2, 3);
    t0 = cyc;
    present();
    drain("port2_only", 50, '1);
    chk("first_beat_latency", first_out_cyc - t0, 2);
    want_order = '{2};
    check_order("port2_only");
    check_cnt("port2_only_cnt");

    // All ports continuously valid with 1-beat packets, from reset.
    do_reset();
    for (int k = 0; k < 2; k++) for (int p = 0; p < NP; p++) push_pkt(p, 1);
    present();
    drain("all_ports", 100, '1);
    want_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_order("all_ports");
    for (int i = 1; i < out_cyc.size(); i++) chk("out_every_other_cycle", out_cyc[i] - out_cyc[i-1], 2);
    check_cnt("all_ports_cnt");

    // Downstream stall of 5 cycles in the middle of a 4-beat packet.
    rdy_mode = 2;
    rdy_val  = 1'b1;
    push_pkt(0, 4);
    start_beats = out_beats;
    present();
    for (int i = 0; i < 20 && out_beats == start_beats; i++) tick();
    chk("stall_setup_first_beat", out_beats - start_beats, 1);
    rdy_val = 1'b0;
    present();
    repeat (5) tick();
    chk("stall_no_beats_taken", out_beats - start_beats, 1);
    rdy_val = 1'b1;
    present();
    drain("stall", 50, '1);
    want_order = '{0};
    check_order("stall");
    rdy_mode = 0;

    // port_en[1] dropped while port 1's packet is in flight.
    for (int k = 0; k < 2; k++) begin
      push_pkt(1, 4);
      push_pkt(0, 2);
      push_pkt(3, 2);
    end
    present();
    for (int i = 0; i < 20 && got_order.size() == 0; i++) tick();
    port_en[1] = 1'b0;
    drain("port_en_off", 200, 4'b1101);
    repeat (5) tick();
    want_order = '{1, 3, 0, 3, 0};
    check_order("port_en_off");
    chk("port1_pkt_held_back", exp_q[1].size(), 4);
    port_en = '1;
    present();
    drain("port_en_on", 50, '1);
    want_order = '{1};
    check_order("port_en_on");
    check_cnt("port_en_cnt");

    // Reset during beat 2 of a 4-beat packet; rr pointer must return to 0.
    push_pkt(2, 4);
    present();
    for (int i = 0; i < 20 && exp_q[2].size() > 3; i++) tick();
    chk("pre_reset_out_valid", bus.out_tvalid, 1);
    do_reset();
    push_pkt(0, 1);
    push_pkt(3, 1);
    present();
    drain("after_reset", 50, '1);
    want_order = '{0, 3};
    check_order("after_reset");

    // Counter wrap from a preloaded all-ones value on port 0.
    preload    = '0;
    preload[0] = '1;
    preload[3] = cnt_model[3];
    force dut.cnt_q = preload;
    tick();
    release dut.cnt_q;
    cnt_model[0] = '1;
    tick();
    check_cnt("preload_cnt");
    push_pkt(0, 1);
    present();
    drain("wrap1", 50, '1);
    chk("cnt_wrap_to_0", pkt_cnt[0 +: CW], 0);
    push_pkt(0, 2);
    present();
    drain("wrap2", 50, '1);
    chk("cnt_after_wrap_1", pkt_cnt[0 +: CW], 1);
    check_cnt("wrap_cnt");

    // Randomized mixes with gaps, backpressure and enable masks.
    gap_en   = 1'b1;
    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      port_en = '0;
      for (int p = 0; p < NP; p++) begin
        npk[p] = $urandom_range(4, 1);
        for (int k = 0; k < npk[p]; k++) push_pkt(p, $urandom_range(6, 1));
      end
      present();
      if (r == 0) begin
        repeat (10) tick();
        chk("en_zero_no_output", got_order.size(), 0);
        chk("en_zero_out_idle", bus.out_tvalid, 0);
        port_en = '1;
      end else begin
        port_en = 4'($urandom_range(15, 1));
      end
      want_order.delete();
      ptr = 0;
      for (int p = 0; p < NP; p++) left[p] = port_en[p] ? npk[p] : 0;
      hit = 1'b1;
      while (hit) begin
        hit  = 1'b0;
        pick = 0;
        for (int k = NP - 1; k >= 0; k--) begin
          if (left[(ptr + k) % NP] > 0) begin
            pick = (ptr + k) % NP;
            hit  = 1'b1;
          end
        end
        if (hit) begin
          want_order.push_back(pick);
          left[pick]--;
          ptr = (pick + 1) % NP;
        end
      end
      present();
      drain("random", 5000, port_en);
      check_order("random");
      check_cnt("random_cnt");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
